axis_dc_filter_mc: RTL and testbench

AXIS_DC_FILTER_MC -- requirements
Module: axis_dc_filter_mc

---
 rtl/axis_dc_filter_mc_pkg.sv | 40 ++++
 rtl/dc_filter_ch.sv | 180 ++++++++++++++++++
 rtl/axis_dc_filter_mc.sv | 117 +++++++++++
 tb/tb_axis_dc_filter_mc.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/axis_dc_filter_mc_pkg.sv
// Shared definitions for the multi-channel AXI-Stream DC-removal filter.
// Holds the fixed Q-format constants, the captured per-strobe control
// record, a generic saturate-to-width helper and the channel-slice helper
// used to index the packed multi-channel buses.
package axis_dc_filter_mc_pkg;

  // Fixed-point layout of the internal LMS words.
  localparam int unsigned LMS_Q_FRAC  = 22;
  localparam int unsigned TAU_WIDTH   = 32;
  localparam int unsigned BUS_WIDTH   = 32;
  localparam int unsigned AC16_WIDTH  = 16;

  // Control fields sampled together with the data on each update strobe.
  typedef struct packed {
    logic [TAU_WIDTH-1:0] tau;
    logic                 zero;
    logic                 freeze;
  } ctrl_t;

  // Clamp a signed value to the range of a signed w-bit word.
  function automatic logic signed [63:0] sat_to_width(input logic signed [63:0] v,
                                                      input int unsigned w);
    logic signed [63:0] max_v;
    logic signed [63:0] min_v;
    max_v = (64'sd1 <<< (w - 1)) - 64'sd1;
    min_v = -(64'sd1 <<< (w - 1));
    if (v > max_v) begin
      return max_v;
    end else if (v < min_v) begin
      return min_v;
    end
    return v;
  endfunction

  // LSB position of channel k on a bus with w bits per channel.
  function automatic int unsigned ch_lsb(input int unsigned k, input int unsigned w);
    return k * w;
  endfunction

endpackage

// File: rtl/dc_filter_ch.sv
// Per-channel DC estimation and removal datapath.
// Ports:
//   clk, rst         clock and asynchronous active-high reset
//   stb_i            update strobe (one valid input beat after decimation)
//   sample_i         signed input sample
//   dc_i, tau_i      manual DC (Q22) and signed Q31 IIR gain, bit31 = manual
//   zero_i           DC-estimate phase marker
//   freeze_i         holds the error history and accumulator
//   sat_clr_i        clears the sticky saturation flag
//   ac_o, ac16_o     AC result in LMS format and as saturated 16-bit integer
//   mdc_o            current DC estimate
//   sat_o            sticky saturation flag
module dc_filter_ch
  import axis_dc_filter_mc_pkg::*;
#(
  parameter int unsigned S_AXIS_DATA_WIDTH = 16,
  parameter int unsigned LMS_DATA_WIDTH    = 26,
  parameter int unsigned LMS_Q_WIDTH       = LMS_Q_FRAC,
  parameter int unsigned AVG_LOG2          = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          stb_i,
  input  logic [S_AXIS_DATA_WIDTH-1:0]  sample_i,
  input  logic [BUS_WIDTH-1:0]          dc_i,
  input  logic [TAU_WIDTH-1:0]          tau_i,
  input  logic                          zero_i,
  input  logic                          freeze_i,
  input  logic                          sat_clr_i,
  output logic [LMS_DATA_WIDTH-1:0]     ac_o,
  output logic [AC16_WIDTH-1:0]         ac16_o,
  output logic [LMS_DATA_WIDTH-1:0]     mdc_o,
  output logic                          sat_o
);

  localparam int L  = int'(LMS_DATA_WIDTH);
  localparam int D  = 1 << AVG_LOG2;
  localparam int SW = L + int'(AVG_LOG2);
  localparam int AW = L + int'(TAU_WIDTH);
  localparam int SH = int'(LMS_Q_WIDTH) - int'(S_AXIS_DATA_WIDTH);
  localparam logic signed [63:0] AC16_RND = (SH > 0) ? (64'sd1 <<< (SH - 1)) : 64'sd0;
  localparam logic signed [63:0] AVG_RND  = (AVG_LOG2 > 0) ? (64'sd1 <<< (AVG_LOG2 - 1)) : 64'sd0;

  logic                 stb1_q, stb1_d;
  logic signed [L-1:0]  m_q, m_d;
  logic signed [L-1:0]  dc_q, dc_d;
  ctrl_t                ctl_q, ctl_d;
  logic signed [L-1:0]  e_sr_q [D];
  logic signed [L-1:0]  e_sr_d [D];
  logic signed [SW-1:0] sum_q, sum_d;
  logic                 upd2_q, upd2_d;
  logic signed [31:0]   tau2_q, tau2_d;
  logic signed [AW-1:0] acc_q, acc_d;
  logic signed [L-1:0]  mdc_q, mdc_d;
  logic signed [L-1:0]  ac_q, ac_d;
  logic signed [15:0]   ac16_q, ac16_d;
  logic                 sat_q, sat_d;

  logic signed [L-1:0]  m_new;
  logic signed [63:0]   ac_full, ac_lim, ac16_full, ac16_lim, e_full, e_lim, mean64;
  logic signed [L-1:0]  mean;
  logic signed [AW-1:0] prod;
  logic signed [AW:0]   acc_sum;
  logic                 sat_set;

  always_comb begin
    stb1_d  = stb_i;
    m_d     = m_q;
    dc_d    = dc_q;
    ctl_d   = ctl_q;
    e_sr_d  = e_sr_q;
    sum_d   = sum_q;
    upd2_d  = 1'b0;
    tau2_d  = tau2_q;
    acc_d   = acc_q;
    mdc_d   = mdc_q;
    ac_d    = ac_q;
    ac16_d  = ac16_q;
    sat_set = 1'b0;

    // Sample placed so its LSB lands LMS_Q_WIDTH-S_AXIS_DATA_WIDTH bits up.
    m_new = L'(signed'(sample_i)) <<< SH;
    if (stb_i) begin
      m_d         = m_new;
      dc_d        = dc_i[L-1:0];
      ctl_d.tau   = tau_i;
      ctl_d.zero  = zero_i;
      ctl_d.freeze = freeze_i;
    end

    ac_full   = 64'(m_q) - 64'(ctl_q.tau[31] ? dc_q : mdc_q);
    ac_lim    = sat_to_width(ac_full, L);
    ac16_full = (ac_lim + AC16_RND) >>> SH;
    ac16_lim  = sat_to_width(ac16_full, AC16_WIDTH);
    e_full    = 64'(m_q) - 64'(mdc_q);
    e_lim     = sat_to_width(e_full, L);
    mean64    = (64'(sum_q) + AVG_RND) >>> AVG_LOG2;
    mean      = mean64[L-1:0];
    // Both operands extended to the accumulator width: the exact product
    // always fits, so the truncated result is the true signed product.
    prod      = {{TAU_WIDTH{mean[L-1]}}, mean} * {{L{tau2_q[31]}}, tau2_q};
    acc_sum   = {acc_q[AW-1], acc_q} + {prod[AW-1], prod};

    // Stage 1: AC output, error push on phase strobes, DC reload otherwise.
    if (stb1_q) begin
      ac_d   = ac_lim[L-1:0];
      ac16_d = ac16_lim[15:0];
      if ((ac_lim != ac_full) || (ac16_lim != ac16_full)) begin
        sat_set = 1'b1;
      end
      if (ctl_q.zero) begin
        if (!ctl_q.freeze) begin
          e_sr_d[0] = e_lim[L-1:0];
          for (int i = 1; i < D; i++) begin
            e_sr_d[i] = e_sr_q[i-1];
          end
          // Running sum: add newest, drop the entry falling off the end.
          sum_d  = sum_q + SW'(e_lim) - SW'(e_sr_q[D-1]);
          upd2_d = 1'b1;
          tau2_d = ctl_q.tau;
        end
      end else begin
        mdc_d = acc_q[AW-1 -: L];
      end
    end

    // Stage 2: saturating accumulator update from the averaged error.
    if (upd2_q) begin
      if (acc_sum[AW] != acc_sum[AW-1]) begin
        acc_d   = acc_sum[AW] ? {1'b1, {(AW-1){1'b0}}} : {1'b0, {(AW-1){1'b1}}};
        sat_set = 1'b1;
      end else begin
        acc_d = acc_sum[AW-1:0];
      end
    end

    // A new saturation event wins over a simultaneous clear.
    sat_d = (sat_q & ~sat_clr_i) | sat_set;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stb1_q <= 1'b0;
      m_q    <= '0;
      dc_q   <= '0;
      ctl_q  <= '0;
      for (int i = 0; i < D; i++) begin
        e_sr_q[i] <= '0;
      end
      sum_q  <= '0;
      upd2_q <= 1'b0;
      tau2_q <= '0;
      acc_q  <= '0;
      mdc_q  <= '0;
      ac_q   <= '0;
      ac16_q <= '0;
      sat_q  <= 1'b0;
    end else begin
      stb1_q <= stb1_d;
      m_q    <= m_d;
      dc_q   <= dc_d;
      ctl_q  <= ctl_d;
      e_sr_q <= e_sr_d;
      sum_q  <= sum_d;
      upd2_q <= upd2_d;
      tau2_q <= tau2_d;
      acc_q  <= acc_d;
      mdc_q  <= mdc_d;
      ac_q   <= ac_d;
      ac16_q <= ac16_d;
      sat_q  <= sat_d;
    end
  end

  assign ac_o   = ac_q;
  assign ac16_o = ac16_q;
  assign mdc_o  = mdc_q;
  assign sat_o  = sat_q;

endmodule

// File: rtl/axis_dc_filter_mc.sv
// Multi-channel AXI-Stream DC-removal filter (top level).
// Decimates valid input beats into update strobes, fans the strobe out to
// NCH independent channel datapaths and produces the AC output valid pulse.
// Ports:
//   aclk, areset        clock and asynchronous active-high reset
//   S_AXIS_*            packed signed input samples, always accepted
//   sc_zero, dc_tau, dc DC-estimate phase, IIR gain / manual select, manual DC
//   freeze, sat_clr     accumulator hold, sticky saturation clear
//   M_AXIS_AC*          AC results (LMS format and 16-bit) with valid pulse
//   dc_mon, sat         DC estimate monitor and sticky saturation flags
module axis_dc_filter_mc
  import axis_dc_filter_mc_pkg::*;
#(
  parameter int unsigned NCH               = 2,
  parameter int unsigned S_AXIS_DATA_WIDTH = 16,
  parameter int unsigned LMS_DATA_WIDTH    = 26,
  parameter int unsigned LMS_Q_WIDTH       = LMS_Q_FRAC,
  parameter int unsigned DECI_LOG2         = 2,
  parameter int unsigned AVG_LOG2          = 2
) (
  input  logic                              aclk,
  input  logic                              areset,
  input  logic [NCH*S_AXIS_DATA_WIDTH-1:0]  S_AXIS_tdata,
  input  logic                              S_AXIS_tvalid,
  input  logic                              sc_zero,
  input  logic [TAU_WIDTH-1:0]              dc_tau,
  input  logic [NCH*BUS_WIDTH-1:0]          dc,
  input  logic                              freeze,
  input  logic                              sat_clr,
  output logic [NCH*BUS_WIDTH-1:0]          M_AXIS_AC_tdata,
  output logic [NCH*AC16_WIDTH-1:0]         M_AXIS_AC16_tdata,
  output logic                              M_AXIS_AC_tvalid,
  output logic [NCH*BUS_WIDTH-1:0]          dc_mon,
  output logic [NCH-1:0]                    sat
);

  localparam int unsigned W = S_AXIS_DATA_WIDTH;
  localparam int unsigned L = LMS_DATA_WIDTH;

  logic strobe;
  logic stb1_q, stb1_d;
  logic tvalid_q, tvalid_d;

  // Strobe on the valid beat where the decimation counter wraps to zero.
  if (DECI_LOG2 == 0) begin : g_nodeci
    assign strobe = S_AXIS_tvalid;
  end else begin : g_deci
    logic [DECI_LOG2-1:0] cnt_q, cnt_d;

    always_comb begin
      cnt_d = cnt_q;
      if (S_AXIS_tvalid) begin
        cnt_d = cnt_q + DECI_LOG2'(1);
      end
    end

    always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_d;
      end
    end

    assign strobe = S_AXIS_tvalid && (cnt_q == '1);
  end

  // Valid follows the channel AC registers, which load one cycle after capture.
  always_comb begin
    stb1_d   = strobe;
    tvalid_d = stb1_q;
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      stb1_q   <= 1'b0;
      tvalid_q <= 1'b0;
    end else begin
      stb1_q   <= stb1_d;
      tvalid_q <= tvalid_d;
    end
  end

  assign M_AXIS_AC_tvalid = tvalid_q;

  for (genvar k = 0; k < NCH; k++) begin : g_ch
    logic [L-1:0]            ac_w;
    logic [L-1:0]            mdc_w;
    logic [AC16_WIDTH-1:0]   ac16_w;

    dc_filter_ch #(
      .S_AXIS_DATA_WIDTH (S_AXIS_DATA_WIDTH),
      .LMS_DATA_WIDTH    (LMS_DATA_WIDTH),
      .LMS_Q_WIDTH       (LMS_Q_WIDTH),
      .AVG_LOG2          (AVG_LOG2)
    ) u_ch (
      .clk       (aclk),
      .rst       (areset),
      .stb_i     (strobe),
      .sample_i  (S_AXIS_tdata[ch_lsb(k, W) +: W]),
      .dc_i      (dc[ch_lsb(k, BUS_WIDTH) +: BUS_WIDTH]),
      .tau_i     (dc_tau),
      .zero_i    (sc_zero),
      .freeze_i  (freeze),
      .sat_clr_i (sat_clr),
      .ac_o      (ac_w),
      .ac16_o    (ac16_w),
      .mdc_o     (mdc_w),
      .sat_o     (sat[k])
    );

    assign M_AXIS_AC_tdata[ch_lsb(k, BUS_WIDTH) +: BUS_WIDTH]    = {{(BUS_WIDTH-L){ac_w[L-1]}}, ac_w};
    assign M_AXIS_AC16_tdata[ch_lsb(k, AC16_WIDTH) +: AC16_WIDTH] = ac16_w;
    assign dc_mon[ch_lsb(k, BUS_WIDTH) +: BUS_WIDTH]             = {{(BUS_WIDTH-L){mdc_w[L-1]}}, mdc_w};
  end

endmodule

// File: tb/tb_axis_dc_filter_mc.sv
// Directed self-checking bench for axis_dc_filter_mc with default parameters
// (2 channels, decimation by 4, 4-deep error average).
module tb_axis_dc_filter_mc;

  logic        aclk = 1'b0;
  logic        areset;
  logic [31:0] S_AXIS_tdata;
  logic        S_AXIS_tvalid;
  logic        sc_zero;
  logic [31:0] dc_tau;
  logic [63:0] dc;
  logic        freeze;
  logic        sat_clr;
  logic [63:0] M_AXIS_AC_tdata;
  logic [31:0] M_AXIS_AC16_tdata;
  logic        M_AXIS_AC_tvalid;
  logic [63:0] dc_mon;
  logic [1:0]  sat;

  int errCount = 0;
  int checkCount = 0;

  axis_dc_filter_mc dut (
    .aclk              (aclk),
    .areset            (areset),
    .S_AXIS_tdata      (S_AXIS_tdata),
    .S_AXIS_tvalid     (S_AXIS_tvalid),
    .sc_zero           (sc_zero),
    .dc_tau            (dc_tau),
    .dc                (dc),
    .freeze            (freeze),
    .sat_clr           (sat_clr),
    .M_AXIS_AC_tdata   (M_AXIS_AC_tdata),
    .M_AXIS_AC16_tdata (M_AXIS_AC16_tdata),
    .M_AXIS_AC_tvalid  (M_AXIS_AC_tvalid),
    .dc_mon            (dc_mon),
    .sat               (sat)
  );

  always #5 aclk = ~aclk;

  // Watchdog so the run always ends on its own.
  initial begin
    #2ms;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic applyStimulus(input logic [15:0] s0, input logic [15:0] s1,
                               input logic vld, input logic zero);
    S_AXIS_tdata  = {s1, s0};
    S_AXIS_tvalid = vld;
    sc_zero       = zero;
    tick();
  endtask

  // Four valid beats: the last one is the strobe beat.
  task automatic doStrobe(input logic [15:0] s0, input logic [15:0] s1, input logic zero);
    repeat (4) applyStimulus(s0, s1, 1'b1, zero);
    S_AXIS_tvalid = 1'b0;
  endtask

  task automatic waitPulse(input string tag);
    int n = 0;
    while (!M_AXIS_AC_tvalid && n < 8) begin
      tick();
      n++;
    end
    checkOutput(tag, 64'(M_AXIS_AC_tvalid), 64'(1));
  endtask

  initial begin
    int pulses;
    int v;
    logic pat [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

    areset        = 1'b1;
    S_AXIS_tdata  = '0;
    S_AXIS_tvalid = 1'b0;
    sc_zero       = 1'b0;
    dc_tau        = '0;
    dc            = '0;
    freeze        = 1'b0;
    sat_clr       = 1'b0;
    #12;

    $display("[TB] reset state");
    checkOutput("rst ac", M_AXIS_AC_tdata, 64'd0);
    checkOutput("rst ac16", 64'(M_AXIS_AC16_tdata), 64'd0);
    checkOutput("rst tvalid", 64'(M_AXIS_AC_tvalid), 64'd0);
    checkOutput("rst dc_mon", dc_mon, 64'd0);
    checkOutput("rst sat", 64'(sat), 64'd0);
    tick();
    areset = 1'b0;
    tick();

    $display("[TB] manual DC mode");
    dc_tau = 32'h8000_0000;
    dc     = {32'd0, 32'd64000};
    doStrobe(16'd1000, 16'd1000, 1'b0);
    checkOutput("man tvalid +1", 64'(M_AXIS_AC_tvalid), 64'd0);
    tick();
    checkOutput("man tvalid +2", 64'(M_AXIS_AC_tvalid), 64'd1);
    checkOutput("man ac16 ch0", 64'(M_AXIS_AC16_tdata[15:0]), 64'(16'd0));
    checkOutput("man ac16 ch1", 64'(M_AXIS_AC16_tdata[31:16]), 64'(16'd1000));
    checkOutput("man ac ch1", 64'(M_AXIS_AC_tdata[63:32]), 64'(32'd64000));
    tick();
    checkOutput("man tvalid +3", 64'(M_AXIS_AC_tvalid), 64'd0);
    checkOutput("man ac16 hold", 64'(M_AXIS_AC16_tdata[31:16]), 64'(16'd1000));

    $display("[TB] gapped tvalid");
    pulses = 0;
    for (int i = 0; i < 7; i++) begin
      applyStimulus(16'd1000, 16'd1000, pat[i], 1'b0);
      if (M_AXIS_AC_tvalid) pulses++;
    end
    S_AXIS_tvalid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (M_AXIS_AC_tvalid) pulses++;
    end
    checkOutput("gap pulse count", 64'(pulses), 64'd1);

    $display("[TB] saturation");
    dc = {32'd64000, 32'hFFE0_0000};
    doStrobe(16'h7FFF, 16'd1000, 1'b0);
    waitPulse("sat pulse");
    checkOutput("sat ac16 ch0", 64'(M_AXIS_AC16_tdata[15:0]), 64'(16'h7FFF));
    checkOutput("sat ac ch0", 64'(M_AXIS_AC_tdata[31:0]), 64'(32'h003F_FFC0));
    checkOutput("sat ac16 ch1", 64'(M_AXIS_AC16_tdata[31:16]), 64'(16'd0));
    checkOutput("sat flags", 64'(sat), 64'(2'b01));
    sat_clr = 1'b1;
    tick();
    sat_clr = 1'b0;
    checkOutput("sat cleared", 64'(sat), 64'(2'b00));
    doStrobe(16'h7FFF, 16'd1000, 1'b0);
    sat_clr = 1'b1;
    tick();
    sat_clr = 1'b0;
    checkOutput("sat set beats clr", 64'(sat), 64'(2'b01));

    $display("[TB] freeze");
    areset = 1'b1;
    tick();
    areset = 1'b0;
    checkOutput("sat after reset", 64'(sat), 64'(2'b00));
    dc_tau = 32'h4000_0000;
    freeze = 1'b1;
    for (int i = 0; i < 10; i++) begin
      doStrobe(16'd1000, 16'd1000, 1'b1);
      doStrobe(16'd1000, 16'd1000, 1'b0);
    end
    waitPulse("frz pulse");
    checkOutput("frz dc_mon ch0", 64'(dc_mon[31:0]), 64'd0);
    checkOutput("frz dc_mon ch1", 64'(dc_mon[63:32]), 64'd0);
    checkOutput("frz ac16 ch0", 64'(M_AXIS_AC16_tdata[15:0]), 64'(16'd1000));
    freeze = 1'b0;
    doStrobe(16'd1000, 16'd1000, 1'b1);
    doStrobe(16'd1000, 16'd1000, 1'b0);
    waitPulse("rel pulse 1");
    checkOutput("rel dc_mon ch0 #1", 64'(dc_mon[31:0]), 64'(32'd4000));
    checkOutput("rel dc_mon ch1 #1", 64'(dc_mon[63:32]), 64'(32'd4000));
    doStrobe(16'd1000, 16'd1000, 1'b1);
    doStrobe(16'd1000, 16'd1000, 1'b0);
    waitPulse("rel pulse 2");
    checkOutput("rel dc_mon ch0 #2", 64'(dc_mon[31:0]), 64'(32'd11750));

    $display("[TB] convergence");
    for (int i = 0; i < 150; i++) begin
      doStrobe(16'd1000, 16'd1000, 1'b1);
      doStrobe(16'd1000, 16'd1000, 1'b0);
    end
    waitPulse("conv pulse");
    v = $signed(dc_mon[31:0]);
    checkOutput("conv dc_mon ch0", 64'((v + 32) >>> 6), 64'(1000));
    v = $signed(dc_mon[63:32]);
    checkOutput("conv dc_mon ch1", 64'((v + 32) >>> 6), 64'(1000));
    checkOutput("conv ac16 ch0", 64'(M_AXIS_AC16_tdata[15:0]), 64'(16'd0));
    checkOutput("conv ac16 ch1", 64'(M_AXIS_AC16_tdata[31:16]), 64'(16'd0));

    $display("[TB] reset mid-pipeline");
    doStrobe(16'd1000, 16'd1000, 1'b1);
    areset = 1'b1;
    #1;
    checkOutput("mid rst dc_mon", dc_mon, 64'd0);
    checkOutput("mid rst ac", M_AXIS_AC_tdata, 64'd0);
    checkOutput("mid rst ac16", 64'(M_AXIS_AC16_tdata), 64'd0);
    checkOutput("mid rst tvalid", 64'(M_AXIS_AC_tvalid), 64'd0);
    tick();
    areset = 1'b0;
    doStrobe(16'd1000, 16'd1000, 1'b0);
    waitPulse("post rst pulse");
    checkOutput("post rst dc_mon ch0", 64'(dc_mon[31:0]), 64'd0);
    checkOutput("post rst ac16 ch0", 64'(M_AXIS_AC16_tdata[15:0]), 64'(16'd1000));

    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end

endmodule
